// File: rtl/hs32_wb_pkg.sv
`default_nettype none
// ============================================================================
// hs32_wb_pkg : shared request type and default sizing for the writeback path
// Revision 1.0
// ============================================================================
package hs32_wb_pkg;

   localparam int c_FIFO_DEPTH    = 2;
   localparam int c_LSU_BURST_MAX = 4;

   typedef struct packed {
      logic [3:0]  addr;
      logic [31:0] data;
      logic        bank;
   } wb_req_t;

   // The alternate bank only has 8 registers, so addr[3] set there is unreachable.
   function automatic logic is_illegal(input wb_req_t req);
      return req.bank & req.addr[3];
   endfunction

endpackage
`default_nettype wire

// File: rtl/hs32_wb_fifo2.sv
`default_nettype none
// ============================================================================
// hs32_wb_fifo2 : small synchronous FIFO of writeback requests
// Revision 1.0
// ============================================================================
module hs32_wb_fifo2
   import hs32_wb_pkg::*;
#(
   parameter int DEPTH = c_FIFO_DEPTH
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push_i,
   input  wb_req_t push_data_i,
   input  logic    pop_i,
   output wb_req_t head_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] c_LAST = PW'(DEPTH - 1);

   wb_req_t       mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          w_push, w_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (w_push) wr_ptr_d = (wr_ptr_q == c_LAST) ? '0 : wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_d = (rd_ptr_q == c_LAST) ? '0 : rd_ptr_q + PW'(1);
      count_d = count_q + CW'(w_push) - CW'(w_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset; occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule
`default_nettype wire

// File: rtl/hs32_wb_arbiter.sv
`default_nettype none
// ============================================================================
// hs32_wb_arbiter : merges ALU and LSU writebacks onto one register-file port
// Revision 1.0
// ============================================================================
module hs32_wb_arbiter
   import hs32_wb_pkg::*;
#(
   parameter int FIFO_DEPTH    = c_FIFO_DEPTH,
   parameter int LSU_BURST_MAX = c_LSU_BURST_MAX
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_valid_i,
   output logic        alu_ready_o,
   input  logic [3:0]  alu_addr_i,
   input  logic [31:0] alu_data_i,
   input  logic        alu_bank_i,
   input  logic        lsu_valid_i,
   output logic        lsu_ready_o,
   input  logic [3:0]  lsu_addr_i,
   input  logic [31:0] lsu_data_i,
   input  logic        lsu_bank_i,
   output logic [3:0]  wp1_addr_o,
   output logic [31:0] wp1_data_o,
   output logic        wp1_we1_o,
   output logic        wp1_we2_o,
   output logic        fwd_valid_o,
   output logic        fwd_bank_o,
   output logic [3:0]  fwd_addr_o,
   output logic [31:0] fwd_data_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int SW = (LSU_BURST_MAX > 0) ? $clog2(LSU_BURST_MAX + 1) : 1;
   localparam logic [SW-1:0] c_STARVE_MAX = SW'(LSU_BURST_MAX);

   wb_req_t w_alu_req, w_lsu_req, w_alu_head, w_lsu_head, w_gnt_req;
   logic    w_alu_full, w_alu_empty, w_lsu_full, w_lsu_empty;
   logic    w_gnt_alu, w_gnt_lsu;

   logic [SW-1:0] starve_q, starve_d;
   logic          out_valid_q, out_valid_d;
   logic          we1_q, we1_d, we2_q, we2_d, err_q, err_d, bank_q, bank_d;
   logic [3:0]    addr_q, addr_d;
   logic [31:0]   data_q, data_d;

   assign w_alu_req   = '{addr: alu_addr_i, data: alu_data_i, bank: alu_bank_i};
   assign w_lsu_req   = '{addr: lsu_addr_i, data: lsu_data_i, bank: lsu_bank_i};
   assign alu_ready_o = ~w_alu_full;
   assign lsu_ready_o = ~w_lsu_full;

   hs32_wb_fifo2 #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (alu_valid_i & alu_ready_o),
      .push_data_i(w_alu_req),
      .pop_i      (w_gnt_alu),
      .head_o     (w_alu_head),
      .full_o     (w_alu_full),
      .empty_o    (w_alu_empty)
   );

   hs32_wb_fifo2 #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (lsu_valid_i & lsu_ready_o),
      .push_data_i(w_lsu_req),
      .pop_i      (w_gnt_lsu),
      .head_o     (w_lsu_head),
      .full_o     (w_lsu_full),
      .empty_o    (w_lsu_empty)
   );

   // LSU has priority until it has taken LSU_BURST_MAX grants past a waiting ALU.
   assign w_gnt_lsu = ~w_lsu_empty & (w_alu_empty | (starve_q != c_STARVE_MAX));
   assign w_gnt_alu = ~w_alu_empty & ~w_gnt_lsu;
   assign w_gnt_req = w_gnt_lsu ? w_lsu_head : w_alu_head;

   always_comb begin
      starve_d = starve_q;
      if (w_gnt_alu || w_alu_empty) begin
         starve_d = '0;
      end else if (w_gnt_lsu && (starve_q != c_STARVE_MAX)) begin
         starve_d = starve_q + SW'(1);
      end
   end

   always_comb begin
      out_valid_d = w_gnt_alu | w_gnt_lsu;
      we1_d  = 1'b0;
      we2_d  = 1'b0;
      err_d  = 1'b0;
      bank_d = bank_q;
      addr_d = addr_q;
      data_d = data_q;
      if (out_valid_d) begin
         bank_d = w_gnt_req.bank;
         data_d = w_gnt_req.data;
         addr_d = w_gnt_req.bank ? {1'b0, w_gnt_req.addr[2:0]} : w_gnt_req.addr;
         err_d  = is_illegal(w_gnt_req);
         we1_d  = ~w_gnt_req.bank;
         we2_d  = w_gnt_req.bank & ~err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q    <= '0;
         out_valid_q <= 1'b0;
         we1_q       <= 1'b0;
         we2_q       <= 1'b0;
         err_q       <= 1'b0;
         bank_q      <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
      end else begin
         starve_q    <= starve_d;
         out_valid_q <= out_valid_d;
         we1_q       <= we1_d;
         we2_q       <= we2_d;
         err_q       <= err_d;
         bank_q      <= bank_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
      end
   end

   assign wp1_addr_o  = addr_q;
   assign wp1_data_o  = data_q;
   assign wp1_we1_o   = we1_q;
   assign wp1_we2_o   = we2_q;
   assign fwd_valid_o = we1_q | we2_q;
   assign fwd_bank_o  = bank_q;
   assign fwd_addr_o  = addr_q;
   assign fwd_data_o  = data_q;
   assign err_o       = err_q;
   assign busy_o      = ~w_alu_empty | ~w_lsu_empty | out_valid_q;

endmodule
`default_nettype wire

// File: doc/hs32_wb_arbiter.md
HS32_WB_ARBITER -- requirements
Module: hs32_wb_arbiter

Interface
REQ-001 Parameters: FIFO_DEPTH, default 2, per-source queue entries; LSU_BURST_MAX, default 4, maximum consecutive LSU grants while ALU waits.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 alu_valid_i / alu_ready_o  in / out  1 / 1  ALU writeback handshake.
REQ-005 alu_addr_i  alu_data_i  alu_bank_i  in  4 / 32 / 1  ALU destination register, value and bank (0 = 16-entry main bank, 1 = 8-entry alternate bank).
REQ-006 lsu_valid_i / lsu_ready_o  in / out  1 / 1  load-unit writeback handshake.
REQ-007 lsu_addr_i  lsu_data_i  lsu_bank_i  in  4 / 32 / 1  load-unit destination, value and bank.
REQ-008 wp1_addr_o  wp1_data_o  out  4 / 32  register-file write address and data.
REQ-009 wp1_we1_o  wp1_we2_o  out  1 / 1  write enable, main bank / alternate bank.
REQ-010 fwd_valid_o  fwd_bank_o  fwd_addr_o  fwd_data_o  out  1 / 1 / 4 / 32  mirror of the write in flight this cycle, for read-port bypass.
REQ-011 err_o  out  1  one-cycle pulse when an illegal write is dropped.
REQ-012 busy_o  out  1  high while any queue entry or output write is pending.

Function
REQ-013 A transfer occurs on a source only when valid and ready are both high at posedge clk; the request is pushed into that source's FIFO.
REQ-014 ready_o SHALL equal FIFO occupancy < FIFO_DEPTH, with no same-cycle pop-through when full.
REQ-015 Each cycle, at most one FIFO head is granted; the grant is registered into the output stage on that edge.
REQ-016 Arbitration: the LSU head wins when both heads are valid, except when the starvation counter equals LSU_BURST_MAX, in which case the ALU wins.
REQ-017 Starvation counter: increments on each LSU grant while the ALU head is valid; clears on any ALU grant or when the ALU FIFO is empty; saturates at LSU_BURST_MAX.
REQ-018 Latency: a request accepted at edge E into an empty FIFO with no competing head is granted at edge E+1; wp1_we* is high during the following cycle, and the register file writes at edge E+2.
REQ-019 The output stage holds for exactly one cycle per grant; wp1_we1_o and wp1_we2_o are never high together.
REQ-020 Bank mapping: bank=0 asserts wp1_we1_o; bank=1 asserts wp1_we2_o, with wp1_addr_o[3] forced to 0.
REQ-021 A granted request with bank=1 and addr[3]=1 is illegal: it is popped, no write enable is asserted, and err_o pulses in the cycle the write would have occurred.
REQ-022 fwd_* equals the output stage every cycle; fwd_valid_o = wp1_we1_o | wp1_we2_o.
REQ-023 Each source writes in its own acceptance order; producers guarantee no two outstanding writes from different sources target the same register, and this block does not check that rule.
REQ-024 busy_o = either FIFO non-empty | output stage valid.

Reset
REQ-025 While reset is high at posedge clk: both FIFOs empty, the output stage is invalid, and the starvation counter is 0.
REQ-026 In the cycle after reset: ready_o = 1, and wp1_we1_o, wp1_we2_o, fwd_valid_o, err_o and busy_o = 0; wp1_addr_o, wp1_data_o, fwd_addr_o and fwd_data_o = 0.
REQ-027 Reset mid-operation discards all queued and in-flight writes, and no write enable is asserted in the cycle after reset.

Structure
REQ-028 Shared package hs32_wb_pkg SHALL hold wb_req_t (addr[3:0], data[31:0], bank) and the default FIFO_DEPTH and LSU_BURST_MAX constants.
REQ-029 One sub-module, hs32_wb_fifo2 (parameterised FIFO of wb_req_t, synchronous reset, push/pop/full/empty), SHALL be instantiated once per source.

Verification
REQ-030 Single ALU write of addr 5, data 0xDEADBEEF, bank 0, accepted at edge E -> wp1_we1_o=1, wp1_addr_o=5, wp1_data_o=0xDEADBEEF, fwd_valid_o=1 in the cycle after E+1, and exactly one write.
REQ-031 LSU and ALU streams valid every cycle, the ALU head pending throughout -> grant order L,L,L,L,A repeats, and the ALU is never starved beyond 4 LSU grants.
REQ-032 LSU write of bank 1, addr 0xB -> no write enable, err_o pulses once, and a following ALU write of bank 1, addr 3 asserts wp1_we2_o with wp1_addr_o=3.
REQ-033 ALU pushes 3 back-to-back while the LSU stream holds the grant -> alu_ready_o low after 2 accepted, and all 3 written in order with values intact.
REQ-034 Reset asserted for one cycle while both FIFOs are full and the output is valid -> no write enable in the cycle after reset, ready_o=1, and busy_o=0.
REQ-035 Random valid and stall stimulus against a reference-model scoreboard -> every accepted request written exactly once, per-source order preserved, and the write enables mutually exclusive.
